// File: rtl/btn_conditioner.sv
// Five-channel push-button conditioner: synchronise, debounce, edge detect.
// Direction buttons optionally auto-repeat while held; center never repeats.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_center_in,
    input  logic       btn_up_in,
    input  logic       btn_left_in,
    input  logic       btn_down_in,
    input  logic       btn_right_in,
    output logic       btn_center,
    output logic       btn_up,
    output logic       btn_left,
    output logic       btn_down,
    output logic       btn_right,
    output logic [4:0] btn_level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [4:0] raw;
    logic [4:0] s1_q;
    logic [4:0] s2_q;
    logic [4:0] stable_q;
    logic [4:0] stable_d;
    logic [4:0] level_q;
    logic [4:0] pulse_q;
    logic [4:0] pulse_d;
    logic [4:0] rep_fire;
    logic [CW-1:0] cnt_q [5];
    logic [CW-1:0] cnt_d [5];

    assign raw = {btn_center_in, btn_up_in, btn_left_in, btn_down_in, btn_right_in};

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Press is seen one stage after stable rises, aligned with btn_level.
    always_comb begin
        pulse_d = (stable_q & ~level_q) | rep_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            level_q  <= '0;
            pulse_q  <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            level_q  <= stable_q;
            pulse_q  <= pulse_d;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rep_fire[4] = 1'b0;

    for (genvar g = 0; g < 4; g++) begin : g_rep
        if (REPEAT_EN != 0) begin : g_on
            localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);
            localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_DELAY - 1);
            localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

            logic [RW-1:0] rep_cnt_q;
            logic [RW-1:0] rep_cnt_d;
            logic          fire;

            // Counting starts the cycle after the press pulse; release zeroes it.
            always_comb begin
                rep_cnt_d = '0;
                fire      = 1'b0;
                if (stable_q[g] && level_q[g]) begin
                    if (rep_cnt_q == REP_LAST) begin
                        rep_cnt_d = REP_RELOAD;
                        fire      = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + RW'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rep_cnt_q <= '0;
                end else begin
                    rep_cnt_q <= rep_cnt_d;
                end
            end

            assign rep_fire[g] = fire;
        end else begin : g_off
            assign rep_fire[g] = 1'b0;
        end
    end

    assign {btn_center, btn_up, btn_left, btn_down, btn_right} = pulse_q;
    assign btn_level = level_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: repeat and no-repeat builds side by side,
// checked every cycle against an edge-counting reference model.
module tb_btn_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_center_in = 1'b0;
    logic btn_up_in = 1'b0;
    logic btn_left_in = 1'b0;
    logic btn_down_in = 1'b0;
    logic btn_right_in = 1'b0;

    logic btn_center, btn_up, btn_left, btn_down, btn_right;
    logic [4:0] btn_level;
    logic nr_center, nr_up, nr_left, nr_down, nr_right;
    logic [4:0] nr_level;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_EN(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_center_in(btn_center_in), .btn_up_in(btn_up_in),
        .btn_left_in(btn_left_in), .btn_down_in(btn_down_in),
        .btn_right_in(btn_right_in),
        .btn_center(btn_center), .btn_up(btn_up), .btn_left(btn_left),
        .btn_down(btn_down), .btn_right(btn_right), .btn_level(btn_level)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_EN(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_nr (
        .clk(clk), .rst(rst),
        .btn_center_in(btn_center_in), .btn_up_in(btn_up_in),
        .btn_left_in(btn_left_in), .btn_down_in(btn_down_in),
        .btn_right_in(btn_right_in),
        .btn_center(nr_center), .btn_up(nr_up), .btn_left(nr_left),
        .btn_down(nr_down), .btn_right(nr_right), .btn_level(nr_level)
    );

    wire [4:0] got_p  = {btn_center, btn_up, btn_left, btn_down, btn_right};
    wire [4:0] got_pn = {nr_center, nr_up, nr_left, nr_down, nr_right};
    wire [19:0] got_all = {got_p, btn_level, got_pn, nr_level};

    // Reference model: input seen two edges late, level flips after D
    // straight disagreeing edges, repeats at press+RD+k*RP while held.
    bit h1 [5];
    bit h2 [5];
    bit m_st [5];
    bit m_lv [5];
    int run [5];
    int t0 [5];
    int cyc = 0;
    logic [4:0] e_p = '0;
    logic [4:0] e_l = '0;
    logic [4:0] e_pn = '0;
    logic [19:0] exp_all;

    function automatic void model_update(input logic r, input logic [4:0] v);
        bit press;
        bit rep;
        cyc++;
        for (int i = 0; i < 5; i++) begin
            if (r) begin
                h1[i] = 0; h2[i] = 0; m_st[i] = 0; m_lv[i] = 0;
                run[i] = 0;
                e_p[i] = 0; e_l[i] = 0; e_pn[i] = 0;
            end else begin
                press = m_st[i] && !m_lv[i];
                if (press) t0[i] = cyc;
                rep = (i != 4) && m_st[i] && m_lv[i] && (cyc - t0[i] >= RD)
                      && ((cyc - t0[i] - RD) % RP == 0);
                e_p[i]  = press | rep;
                e_pn[i] = press;
                e_l[i]  = m_st[i];
                m_lv[i] = m_st[i];
                if (h2[i] != m_st[i]) begin
                    run[i]++;
                    if (run[i] == D) begin
                        m_st[i] = h2[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
                h2[i] = h1[i];
                h1[i] = v[i];
            end
        end
        exp_all = {e_p, e_l, e_pn, e_l};
    endfunction

    task automatic step(input logic r, input logic [4:0] v);
        @(negedge clk);
        rst = r;
        {btn_center_in, btn_up_in, btn_left_in, btn_down_in, btn_right_in} = v;
        @(posedge clk);
        model_update(r, v);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 11; i++) begin
            step(i < 10, 5'b00000);
            n_cmp++;
            if (got_all !== 20'h0 || got_all !== exp_all) begin
                n_fail++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", i, got_all, exp_all);
            end
        end
    endtask

    task automatic test_up_repeat();
        for (int i = 0; i < 50; i++) begin
            step(1'b0, (i < 30) ? 5'b01000 : 5'b00000);
            n_cmp++;
            if (got_all !== exp_all) begin
                n_fail++;
                $display("FAIL up_model edge=%0d got=%b exp=%b", i, got_all, exp_all);
            end
            if (i == 5 || i == 6 || i == 26 || i == 35 || i == 36) begin
                n_cmp++;
                if ({btn_up, btn_level[3]} !==
                    ((i == 5) ? 2'b00 : (i == 6) ? 2'b11 : (i == 26) ? 2'b11 :
                     (i == 35) ? 2'b01 : 2'b00)) begin
                    n_fail++;
                    $display("FAIL up_timing edge=%0d got pulse=%b level=%b",
                             i, btn_up, btn_level[3]);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [6:0] pat;
        pat = 7'b1110111;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (i < 7 && pat[6 - i]) ? 5'b00100 : 5'b00000);
            n_cmp++;
            if (got_all !== exp_all || btn_left !== 1'b0 || btn_level[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce edge=%0d got=%b exp=%b", i, got_all, exp_all);
            end
        end
    endtask

    task automatic test_center();
        int pulses;
        int at;
        pulses = 0;
        at = -1;
        for (int i = 0; i < 75; i++) begin
            step(1'b0, (i < 60) ? 5'b10000 : 5'b00000);
            n_cmp++;
            if (got_all !== exp_all) begin
                n_fail++;
                $display("FAIL center_model edge=%0d got=%b exp=%b", i, got_all, exp_all);
            end
            if (btn_center === 1'b1) begin
                pulses++;
                at = i;
            end
        end
        n_cmp++;
        if (pulses !== 1 || at !== 6) begin
            n_fail++;
            $display("FAIL center_once got %0d pulses last at %0d, need 1 at 6", pulses, at);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 55; i++) begin
            step(1'b0, (i < 40) ? 5'b00011 : 5'b00000);
            n_cmp++;
            if (got_all !== exp_all || btn_down !== btn_right) begin
                n_fail++;
                $display("FAIL dr_model edge=%0d got=%b exp=%b", i, got_all, exp_all);
            end
            if (i == 6 || i == 26 || i == 34 || i == 42) begin
                n_cmp++;
                if ({btn_down, btn_right} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL dr_pulse edge=%0d got %b%b need 11", i, btn_down, btn_right);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int nr_pulses;
        nr_pulses = 0;
        for (int i = 0; i < 112; i++) begin
            step(i == 10 || i == 11, 5'b01000);
            n_cmp++;
            if (got_all !== exp_all) begin
                n_fail++;
                $display("FAIL rstmid_model edge=%0d got=%b exp=%b", i, got_all, exp_all);
            end
            if (i == 10 || i == 11 || i == 12 || i == 17 || i == 18) begin
                n_cmp++;
                if (btn_up !== (i == 18)) begin
                    n_fail++;
                    $display("FAIL rstmid_pulse edge=%0d got %b need %b", i, btn_up, i == 18);
                end
            end
            if (i >= 12 && nr_up === 1'b1) nr_pulses++;
        end
        n_cmp++;
        if (nr_pulses !== 1) begin
            n_fail++;
            $display("FAIL norepeat_count got %0d pulses need 1", nr_pulses);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 5'b00000);
    endtask

    task automatic test_random();
        logic [4:0] v;
        int hold [5];
        v = '0;
        for (int c = 0; c < 5; c++) hold[c] = 0;
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < 5; c++) begin
                if (hold[c] == 0) begin
                    v[c] = 1'($urandom_range(0, 1));
                    hold[c] = (($urandom & 3) == 0) ? $urandom_range(20, 45)
                                                     : $urandom_range(1, 6);
                end
                hold[c]--;
            end
            step(($urandom % 160) == 0, v);
            n_cmp++;
            if (got_all !== exp_all) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, got_all, exp_all);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_repeat();
        test_bounce();
        test_center();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
